// File: rtl/idu_stage_pkg.sv
// Shared decode constants, exu operand-select / operation codes and the decoded bundle type.
package idu_stage_pkg;
   localparam int CPU_W         = 64;
   localparam int INST_W        = 32;
   localparam int REG_W         = 5;
   localparam int EXU_SEL_WIDTH = 2;
   localparam int EXU_OPT_WIDTH = 4;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [6:0]  F7_BASE     = 7'b0000000;
   localparam logic [6:0]  F7_ALT      = 7'b0100000;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   typedef enum logic [EXU_SEL_WIDTH-1:0] {SEL_REG, SEL_IMM, SEL_PC4, SEL_PCI} src_sel_e;

   typedef enum logic [EXU_OPT_WIDTH-1:0] {
      OPT_ADD, OPT_SUB, OPT_SLL, OPT_SLT, OPT_SLTU, OPT_XOR, OPT_SRL, OPT_SRA,
      OPT_OR, OPT_AND, OPT_BEQ, OPT_BNE, OPT_BLT, OPT_BGE, OPT_BLTU, OPT_BGEU
   } opt_e;

   typedef struct packed {
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
      logic             rd_wen;
      logic [CPU_W-1:0] imm;
      src_sel_e         src_sel;
      opt_e             opt;
      logic             branch;
      logic             jump;
      logic             illegal;
      logic             ebreak;
   } dec_bundle_t;

   // alt selects sub/sra; callers gate it to the encodings where it is meaningful
   function automatic opt_e alu_opt(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0:    return alt ? OPT_SUB : OPT_ADD;
         3'd1:    return OPT_SLL;
         3'd2:    return OPT_SLT;
         3'd3:    return OPT_SLTU;
         3'd4:    return OPT_XOR;
         3'd5:    return alt ? OPT_SRA : OPT_SRL;
         3'd6:    return OPT_OR;
         default: return OPT_AND;
      endcase
   endfunction

   function automatic opt_e br_opt(input logic [2:0] f3);
      case (f3)
         3'd1:    return OPT_BNE;
         3'd4:    return OPT_BLT;
         3'd5:    return OPT_BGE;
         3'd6:    return OPT_BLTU;
         3'd7:    return OPT_BGEU;
         default: return OPT_BEQ;
      endcase
   endfunction
endpackage

// File: rtl/idu_dec.sv
// Combinational RV64I decode: instruction word -> exu control bundle.
module idu_dec
   import idu_stage_pkg::*;
(
   input  logic [INST_W-1:0] inst,
   output dec_bundle_t       bundle
);
   logic [6:0]       opcode, f7;
   logic [2:0]       f3;
   logic [CPU_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic             ill, wen;

   assign opcode = inst[6:0];
   assign f3     = inst[14:12];
   assign f7     = inst[31:25];
   assign imm_i  = {{(CPU_W-12){inst[31]}}, inst[31:20]};
   assign imm_s  = {{(CPU_W-12){inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b  = {{(CPU_W-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u  = {{(CPU_W-32){inst[31]}}, inst[31:12], 12'h000};
   assign imm_j  = {{(CPU_W-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   always_comb begin
      bundle         = '0;
      bundle.rs1     = inst[19:15];
      bundle.rs2     = inst[24:20];
      bundle.rd      = inst[11:7];
      bundle.src_sel = SEL_REG;
      bundle.opt     = OPT_ADD;
      ill            = 1'b0;
      wen            = 1'b0;
      case (opcode)
         OPC_LUI: begin
            bundle.imm = imm_u; bundle.rs1 = '0; bundle.src_sel = SEL_IMM; wen = 1'b1;
         end
         OPC_AUIPC: begin
            bundle.imm = imm_u; bundle.src_sel = SEL_PCI; wen = 1'b1;
         end
         OPC_JAL: begin
            bundle.imm = imm_j; bundle.src_sel = SEL_PC4; bundle.jump = 1'b1; wen = 1'b1;
         end
         OPC_JALR: begin
            if (f3 != 3'd0) ill = 1'b1;
            else begin
               bundle.imm = imm_i; bundle.src_sel = SEL_PC4; bundle.jump = 1'b1; wen = 1'b1;
            end
         end
         OPC_BRANCH: begin
            if (f3[2:1] == 2'b01) ill = 1'b1;
            else begin
               bundle.imm = imm_b; bundle.opt = br_opt(f3); bundle.branch = 1'b1;
            end
         end
         OPC_LOAD: begin
            if (f3 == 3'd7) ill = 1'b1;
            else begin
               bundle.imm = imm_i; bundle.src_sel = SEL_IMM; wen = 1'b1;
            end
         end
         OPC_STORE: begin
            if (f3[2]) ill = 1'b1;
            else begin
               bundle.imm = imm_s; bundle.src_sel = SEL_IMM;
            end
         end
         OPC_OPIMM: begin
            // RV64 shifts carry a 6-bit shamt; only imm[11:6] = 0 / 010000 are legal
            if ((f3 == 3'd1 && inst[31:26] != 6'b000000) ||
                (f3 == 3'd5 && inst[31:26] != 6'b000000 && inst[31:26] != 6'b010000)) ill = 1'b1;
            else begin
               bundle.imm     = imm_i;
               bundle.src_sel = SEL_IMM;
               bundle.opt     = alu_opt(f3, (f3 == 3'd5) & inst[30]);
               wen            = 1'b1;
            end
         end
         OPC_OP: begin
            if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5))) begin
               bundle.opt = alu_opt(f3, inst[30]);
               wen        = 1'b1;
            end else ill = 1'b1;
         end
         OPC_SYSTEM: begin
            if (inst == INST_EBREAK) bundle.ebreak = 1'b1;
            else ill = 1'b1;
         end
         default: ill = 1'b1;
      endcase
      bundle.illegal = ill;
      bundle.rd_wen  = wen & (bundle.rd != '0);
   end
endmodule

// File: rtl/idu_stage.sv
// Decode stage: one-entry pipeline register with valid/ready backpressure and flush around idu_dec.
module idu_stage
   import idu_stage_pkg::*;
#(
   parameter int CPU_WIDTH  = CPU_W,
   parameter int INST_WIDTH = INST_W,
   parameter int REG_AW     = REG_W
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [INST_WIDTH-1:0]    i_inst,
   input  logic [CPU_WIDTH-1:0]     i_pc,
   input  logic                     i_flush,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [CPU_WIDTH-1:0]     o_pc,
   output logic [REG_AW-1:0]        o_rs1_idx,
   output logic [REG_AW-1:0]        o_rs2_idx,
   output logic [REG_AW-1:0]        o_rd_idx,
   output logic                     o_rd_wen,
   output logic [CPU_WIDTH-1:0]     o_imm,
   output logic [EXU_SEL_WIDTH-1:0] o_src_sel,
   output logic [EXU_OPT_WIDTH-1:0] o_opt,
   output logic                     o_branch,
   output logic                     o_jump,
   output logic                     o_illegal,
   output logic                     o_ebreak
);
   dec_bundle_t          dec, bnd;
   logic [CPU_WIDTH-1:0] pc_q;
   logic                 vld, accept;

   idu_dec u_dec (.inst(i_inst), .bundle(dec));

   // o_ready ignores flush so the IFU sees a stable handshake; flush only drops the data
   assign o_ready = ~vld | i_ready;
   assign accept  = i_valid & o_ready & ~i_flush;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld  <= 1'b0;
         bnd  <= '0;
         pc_q <= '0;
      end else begin
         if (i_flush)      vld <= 1'b0;
         else if (accept)  vld <= 1'b1;
         else if (i_ready) vld <= 1'b0;
         if (accept) begin
            bnd  <= dec;
            pc_q <= i_pc;
         end
      end
   end

   assign o_valid   = vld;
   assign o_pc      = pc_q;
   assign o_rs1_idx = bnd.rs1;
   assign o_rs2_idx = bnd.rs2;
   assign o_rd_idx  = bnd.rd;
   assign o_rd_wen  = bnd.rd_wen;
   assign o_imm     = bnd.imm;
   assign o_src_sel = bnd.src_sel;
   assign o_opt     = bnd.opt;
   assign o_branch  = bnd.branch;
   assign o_jump    = bnd.jump;
   assign o_illegal = bnd.illegal;
   assign o_ebreak  = bnd.ebreak;
endmodule
